// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR PRBS generator: feedback topology selectors
// and maximal-length tap masks for the common register widths.
package lfsr_pkg;

   localparam int unsigned LFSR_FIB = 0;
   localparam int unsigned LFSR_GAL = 1;

   localparam logic [3:0]  LFSR_TAPS4  = 4'hC;
   localparam logic [7:0]  LFSR_TAPS8  = 8'hB8;
   localparam logic [15:0] LFSR_TAPS16 = 16'hB400;
   localparam logic [31:0] LFSR_TAPS32 = 32'h80200003;

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR next-state function, Fibonacci (left shift, XOR feedback
// into bit 0) or Galois (right shift, tap mask applied when bit 0 is set).
module lfsr_next
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = 4,
   parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS4,
   parameter int unsigned      MODE  = LFSR_FIB
) (
   input  logic [WIDTH-1:0] state,
   output logic [WIDTH-1:0] next
);

   logic fb;

   always_comb begin
      fb   = ^(state & TAPS);
      next = '0;
      if (MODE == LFSR_GAL)
         next = (state >> 1) ^ (state[0] ? TAPS : '0);
      else
         next = {state[WIDTH-2:0], fb};
   end

endmodule

// File: rtl/lfsr_prbs_gen.sv
// PRBS source: LFSR state with step enable, runtime seed load, zero-seed
// lock-up recovery and a period monitor against the captured start state.
module lfsr_prbs_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = 4,
   parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS4,
   parameter logic [WIDTH-1:0] SEED  = 4'b0001,
   parameter int unsigned      MODE  = LFSR_FIB
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] q,
   output logic             bit_out,
   output logic [WIDTH-1:0] cnt,
   output logic             wrap,
   output logic             lockup
);

   logic [WIDTH-1:0] start;
   logic [WIDTH-1:0] nxt;

   lfsr_next #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .MODE  (MODE)
   ) u_next (
      .state (q),
      .next  (nxt)
   );

   assign bit_out = (MODE == LFSR_GAL) ? q[0] : q[WIDTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         q      <= SEED;
         start  <= SEED;
         cnt    <= '0;
         wrap   <= 1'b0;
         lockup <= 1'b0;
      end else if (load) begin
         cnt  <= '0;
         wrap <= 1'b0;
         // A zero seed would lock the register; substitute SEED and flag it.
         if (seed_in != '0) begin
            q      <= seed_in;
            start  <= seed_in;
            lockup <= 1'b0;
         end else begin
            q      <= SEED;
            start  <= SEED;
            lockup <= 1'b1;
         end
      end else if (en) begin
         q      <= nxt;
         lockup <= 1'b0;
         if (nxt == start) begin
            cnt  <= '0;
            wrap <= 1'b1;
         end else begin
            cnt  <= cnt + WIDTH'(1);
            wrap <= 1'b0;
         end
      end else begin
         wrap   <= 1'b0;
         lockup <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Directed bench for lfsr_prbs_gen: 4-bit Fibonacci and Galois instances
// checked against hand-computed state sequences.
module tb_lfsr_prbs_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [3:0] seed_in = '0;
   logic [3:0] q, cnt;
   logic       bit_out, wrap, lockup;

   logic       g_en = 1'b0;
   logic       g_load = 1'b0;
   logic [3:0] g_seed_in = '0;
   logic [3:0] g_q, g_cnt;
   logic       g_bit_out, g_wrap, g_lockup;

   int total = 0;
   int bad   = 0;

   logic [3:0] fseq [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                             4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
   logic [3:0] aseq [15] = '{4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1,
                             4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA};
   logic [3:0] gseq [15] = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                             4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};

   always #5 clk = ~clk;

   lfsr_prbs_gen #(
      .WIDTH (4),
      .TAPS  (4'b1100),
      .SEED  (4'b0001),
      .MODE  (0)
   ) dut_fib (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .load    (load),
      .seed_in (seed_in),
      .q       (q),
      .bit_out (bit_out),
      .cnt     (cnt),
      .wrap    (wrap),
      .lockup  (lockup)
   );

   lfsr_prbs_gen #(
      .WIDTH (4),
      .TAPS  (4'b1100),
      .SEED  (4'b0001),
      .MODE  (1)
   ) dut_gal (
      .clk     (clk),
      .rst     (rst),
      .en      (g_en),
      .load    (g_load),
      .seed_in (g_seed_in),
      .q       (g_q),
      .bit_out (g_bit_out),
      .cnt     (g_cnt),
      .wrap    (g_wrap),
      .lockup  (g_lockup)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset
      rst = 1'b1;
      step();
      chk("rst_q", q, 4'h1);
      chk("rst_cnt", cnt, 4'h0);
      chk("rst_wrap", wrap, 1'b0);
      chk("rst_lockup", lockup, 1'b0);
      chk("rst_bit", bit_out, 1'b0);
      chk("rst_gq", g_q, 4'h1);
      chk("rst_gbit", g_bit_out, 1'b1);
      rst = 1'b0;

      // first five steps, then a 5-cycle pause at 0110
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("fib_q", q, fseq[i]);
         chk("fib_cnt", cnt, i + 1);
         chk("fib_wrap", wrap, 1'b0);
      end
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_q", q, 4'h6);
         chk("hold_cnt", cnt, 4'h5);
         chk("hold_wrap", wrap, 1'b0);
         chk("hold_lockup", lockup, 1'b0);
      end
      en = 1'b1;
      for (int i = 5; i < 15; i++) begin
         step();
         chk("fib_q", q, fseq[i]);
         chk("fib_bit", bit_out, fseq[i][3]);
         chk("fib_cnt", cnt, (i == 14) ? 0 : i + 1);
         chk("fib_wrap", wrap, (i == 14) ? 1'b1 : 1'b0);
      end

      // two steps, then zero-seed load
      step();
      step();
      chk("pre_load_q", q, 4'h4);
      chk("pre_load_wrap", wrap, 1'b0);
      en = 1'b0;
      load = 1'b1;
      seed_in = 4'h0;
      step();
      chk("zload_q", q, 4'h1);
      chk("zload_cnt", cnt, 4'h0);
      chk("zload_lockup", lockup, 1'b1);
      load = 1'b0;
      step();
      chk("zload_pulse_end", lockup, 1'b0);
      chk("zload_hold_q", q, 4'h1);

      // load wins over en
      load = 1'b1;
      en = 1'b1;
      seed_in = 4'hA;
      step();
      chk("load_en_q", q, 4'hA);
      chk("load_en_cnt", cnt, 4'h0);
      chk("load_en_lockup", lockup, 1'b0);
      load = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         chk("seedA_q", q, aseq[i]);
         chk("seedA_wrap", wrap, (i == 14) ? 1'b1 : 1'b0);
         chk("seedA_cnt", cnt, (i == 14) ? 0 : i + 1);
      end

      // reset at step 7 of a fresh run, with load and en both pending
      rst = 1'b1;
      en = 1'b0;
      step();
      rst = 1'b0;
      en = 1'b1;
      for (int i = 0; i < 7; i++) step();
      chk("mid_q", q, 4'hA);
      chk("mid_cnt", cnt, 4'h7);
      rst = 1'b1;
      load = 1'b1;
      seed_in = 4'h5;
      step();
      chk("midrst_q", q, 4'h1);
      chk("midrst_cnt", cnt, 4'h0);
      chk("midrst_wrap", wrap, 1'b0);
      rst = 1'b0;
      load = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         chk("restart_q", q, fseq[i]);
         chk("restart_wrap", wrap, (i == 14) ? 1'b1 : 1'b0);
      end
      en = 1'b0;

      // Galois instance
      chk("gal_idle_q", g_q, 4'h1);
      g_en = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step();
         chk("gal_q", g_q, gseq[i]);
         chk("gal_bit", g_bit_out, gseq[i][0]);
         chk("gal_cnt", g_cnt, (i == 14) ? 0 : i + 1);
         chk("gal_wrap", g_wrap, (i == 14) ? 1'b1 : 1'b0);
      end
      g_en = 1'b0;
      step();
      chk("gal_wrap_end", g_wrap, 1'b0);
      chk("gal_lockup", g_lockup, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lfsr_prbs_gen.md
# lfsr_prbs_gen

Parametrised linear-feedback shift register for pseudo-random pattern generation in the sequential test circuits. Width, tap polynomial, reset seed and feedback topology (Fibonacci or Galois) are set at elaboration. Adds step enable, runtime seed load, all-zero lock-up recovery and a period monitor that flags each full return to the start state. Sits beside counters and stimulus blocks as the standard PRBS source and checker reference.

## Interface

- WIDTH, 4: register width, 2..32
- TAPS, 4'b1100: feedback tap mask, WIDTH bits, bit i set means stage i taps (default x^4+x^3+1)
- SEED, 4'b0001: reset value and lock-up recovery value, must be nonzero
- MODE, 0: 0 = Fibonacci, 1 = Galois

- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous active-high; one clock, reset is synchronous and active-high
- en  in  1  advance one step this cycle
- load  in  1  load seed_in this cycle
- seed_in  in  WIDTH  runtime seed
- q  out  WIDTH  current register state
- bit_out  out  1  serial output: q[WIDTH-1] (Fibonacci), q[0] (Galois)
- cnt  out  WIDTH  steps taken since start state was captured
- wrap  out  1  one-cycle pulse when state returns to start state
- lockup  out  1  one-cycle pulse when an all-zero state is replaced by SEED

## Operation

- Fibonacci: fb = XOR of q[i] over TAPS[i]=1; next = {q[WIDTH-2:0], fb}. Feedback is XOR only, never AND/OR.
- Galois (right shift): next = (q >> 1) ^ (q[0] ? TAPS : 0).
- Priority per cycle: rst > load > en > hold.
- rst: q=SEED, start=SEED, cnt=0, wrap=0, lockup=0.
- load: if seed_in != 0, q=seed_in and start=seed_in; if seed_in == 0, q=SEED, start=SEED, lockup=1. cnt=0 in both cases. en ignored that cycle.
- en (no load): q=next; cnt=cnt+1, except when next == start, then cnt=0 and wrap=1.
- Hold (en=0, load=0): q, cnt unchanged; wrap=lockup=0.
- The state register never holds all-zero. The zero-seed substitution is the only lock-up path.
- cnt is WIDTH bits. Max period 2^WIDTH-1 fits without overflow. For non-maximal TAPS, cnt wraps at start-state return, not at overflow.

## Timing

- All outputs registered. Reset values: q=SEED, cnt=0, wrap=0, lockup=0, bit_out per MODE from SEED.
- Latency: en sampled at edge N, new q visible after edge N. wrap and lockup pulse in the same cycle as the q update that caused them, for exactly one cycle.
- Back-to-back en advances every cycle, with no bubbles.
- rst mid-run takes effect at the next edge regardless of en/load. The interrupted run leaves no residue.
- load and en together: load wins and the step is dropped.

## Structure

- Package lfsr_pkg:
  - mode constants LFSR_FIB=0, LFSR_GAL=1
  - maximal default tap masks for WIDTH 4, 8, 16, 32: 4'hC, 8'hB8, 16'hB400, 32'h80200003
- Sub-module lfsr_next: purely combinational next-state function (WIDTH, TAPS, MODE), state in, next out. Reused by the checker bench as the golden model.
- Top module holds the state, start, cnt and pulse registers.

## Test plan

- Reset, Fibonacci, defaults: rst high 1 cycle -> q=0001, cnt=0, wrap=0.
- 15 steps with en held high -> q follows 0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000,0001. wrap=1 only on the 15th step, with cnt returning to 0.
- en low for 5 cycles mid-sequence at q=0110 -> q and cnt frozen, no pulses.
- load with seed_in=0000 -> q=0001, cnt=0, lockup=1 for one cycle. load with seed_in=1010 together with en=1 -> q=1010 and no step taken. After 15 further steps, wrap fires at q=1010.
- MODE=1, TAPS=4'b1100 -> 0001,1100,0110,0011,1101. bit_out=q[0]. wrap after 15 steps.
- rst asserted at step 7 of a run -> q=0001, cnt=0 at the next edge. The sequence restarts identically.
